// File: rtl/veda_pkg.sv
// veda_pkg: shared state encoding, memory-mode constants and default sizes for the VEDA data-memory arbiter
package veda_pkg;
    localparam int VEDA_ADDR_W = 9;
    localparam int VEDA_DATA_W = 32;
    localparam int VEDA_DEPTH = 100;
    localparam logic MEM_MODE_WRITE = 1'b0;
    localparam logic MEM_MODE_READ = 1'b1;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
endpackage

// File: rtl/veda_rr_arb2.sv
// veda_rr_arb2: two-requester picker, round-robin (ARB_MODE=0) or port-0 fixed priority (ARB_MODE=1)
module veda_rr_arb2 #(
    parameter int ARB_MODE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] win
);
    logic rr_last;
    // The pointer only moves on a tie; a lone requester always wins outright
    always_comb win = (req == 2'b11) ? ((ARB_MODE != 0 || rr_last) ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_last <= 1'b1;
        else if (en && req == 2'b11) rr_last <= win[1];
    end
endmodule

// File: rtl/veda_dmem_arbiter.sv
// veda_dmem_arbiter: shares the VEDA data-memory port between the core LSU (port 0) and loader/debug (port 1),
// one range-checked access at a time with a registered response to the winner.
module veda_dmem_arbiter
    import veda_pkg::*;
#(
    parameter int ADDR_W = VEDA_ADDR_W,
    parameter int DATA_W = VEDA_DATA_W,
    parameter int DEPTH = VEDA_DEPTH,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_w_en,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout,
    output logic              busy
);
    state_t state, nxt;
    logic [1:0] win;
    logic go, wr, acc, s_we, s_ill, l_id, l_we, l_ill;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata, rsp;

    veda_rr_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
        .clk(clk),
        .rst_n(rst_n),
        .en(state == ST_IDLE),
        .req({p1_req, p0_req}),
        .win(win)
    );

    always_comb begin
        go = state == ST_IDLE && (p0_req || p1_req);
        acc = state == ST_ACCESS;
        s_we = win[1] ? p1_we : p0_we;
        s_addr = win[1] ? p1_addr : p0_addr;
        s_wdata = win[1] ? p1_wdata : p0_wdata;
        s_ill = 32'(s_addr) >= DEPTH;
        wr = go && s_we && !s_ill;
        // A legal write echoes the data already parked on mem_datain
        rsp = l_ill ? '0 : l_we ? mem_datain : mem_dataout;
        nxt = acc ? ST_RESP : go ? ST_ACCESS : ST_IDLE;
        busy = state != ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= nxt;
    end

    // Memory controls are set up on the grant edge so they are live for exactly the ACCESS cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_id <= 1'b0;
            l_we <= 1'b0;
            l_ill <= 1'b0;
            p0_gnt <= 1'b0;
            p1_gnt <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_err <= 1'b0;
            p1_err <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            mem_w_en <= 1'b0;
            mem_mode <= MEM_MODE_READ;
            mem_address <= '0;
            mem_datain <= '0;
        end else begin
            p0_gnt <= go && win[0];
            p1_gnt <= go && win[1];
            mem_w_en <= wr;
            mem_mode <= wr ? MEM_MODE_WRITE : MEM_MODE_READ;
            p0_rvalid <= acc && !l_id;
            p1_rvalid <= acc && l_id;
            p0_err <= acc && !l_id && l_ill;
            p1_err <= acc && l_id && l_ill;
            p0_rdata <= (acc && !l_id) ? rsp : '0;
            p1_rdata <= (acc && l_id) ? rsp : '0;
            if (go) begin
                l_id <= win[1];
                l_we <= s_we;
                l_ill <= s_ill;
                mem_address <= s_addr;
            end
            if (wr) mem_datain <= s_wdata;
        end
    end
endmodule

// File: tb/tb_veda_dmem_arbiter.sv
// tb_veda_dmem_arbiter: randomized scoreboard bench with a transaction-level reference model and a
// behavioural data memory attached to the memory port.
module tb_veda_dmem_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int DEPTH = 100;

    logic clk = 1'b0, rst_n = 1'b0, load = 1'b1;
    always #5 clk = ~clk;

    logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic mem_w_en, mem_mode, busy;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_datain, mem_dataout;

    logic f_p0_gnt, f_p0_rvalid, f_p0_err, f_p1_gnt, f_p1_rvalid, f_p1_err;
    logic [DW-1:0] f_p0_rdata, f_p1_rdata, f_din;
    logic f_wen, f_mode, f_busy;
    logic [AW-1:0] f_addr;

    veda_dmem_arbiter #(.ARB_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_w_en(mem_w_en), .mem_mode(mem_mode), .mem_address(mem_address),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout), .busy(busy)
    );

    veda_dmem_arbiter #(.ARB_MODE(1)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata), .p0_err(f_p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata), .p1_err(f_p1_err),
        .mem_w_en(f_wen), .mem_mode(f_mode), .mem_address(f_addr),
        .mem_datain(f_din), .mem_dataout(32'h0), .busy(f_busy)
    );

    function automatic logic [DW-1:0] f(int i);
        return 32'(i) * 32'h0101_0101 + 32'd3;
    endfunction

    logic [DW-1:0] mem [512];
    assign mem_dataout = mem[mem_address];
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 512; i++) mem[i] <= f(i);
        else if (mem_w_en && !mem_mode) mem[mem_address] <= mem_datain;
    end

    typedef struct {
        bit port;
        bit err;
        logic [DW-1:0] data;
        int due;
    } rsp_t;
    rsp_t sbq[$];
    logic [DW-1:0] ref_mem [512];
    int vec = 0, bad = 0, cyc = 0, cool = 0, fcnt = 0;
    bit last = 1, keep = 0, pw_valid = 0;
    logic [AW-1:0] pw_addr;
    logic [DW-1:0] pw_data;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic issue(bit port, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        if (port) begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; end
        else begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; end
    endtask

    // Model: one access per grant, a grant at most every third edge, ties broken away from the last tie winner
    task automatic step();
        bit w, g0, g1, wen, we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        g0 = 0; g1 = 0; wen = 0; we = 0; w = 0; a = '0; d = '0;
        cyc++;
        if (pw_valid) begin ref_mem[pw_addr] = pw_data; pw_valid = 0; end
        if (cool > 0) cool--;
        else if (rst_n && (p0_req || p1_req)) begin
            w = (p0_req && p1_req) ? !last : p1_req;
            if (p0_req && p1_req) last = w;
            a = w ? p1_addr : p0_addr;
            d = w ? p1_wdata : p0_wdata;
            we = w ? p1_we : p0_we;
            g0 = !w; g1 = w; cool = 2;
            if (a >= DEPTH) sbq.push_back(rsp_t'{w, 1'b1, '0, cyc + 1});
            else if (we) begin
                wen = 1; pw_valid = 1; pw_addr = a; pw_data = d;
                sbq.push_back(rsp_t'{w, 1'b0, d, cyc + 1});
            end else sbq.push_back(rsp_t'{w, 1'b0, ref_mem[a], cyc + 1});
            if (!keep) begin if (w) p1_req = 0; else p0_req = 0; end
        end
        chk("p0_gnt", 32'(p0_gnt), 32'(g0));
        chk("p1_gnt", 32'(p1_gnt), 32'(g1));
        chk("mem_w_en", 32'(mem_w_en), 32'(wen));
        chk("mem_mode", 32'(mem_mode), 32'(!wen));
        chk("busy", 32'(busy), 32'(cool > 0));
        if (g0 || g1) chk("mem_address", 32'(mem_address), 32'(a));
        if (wen) chk("mem_datain", mem_datain, d);
    endtask

    task automatic tick();
        @(negedge clk);
        step();
    endtask

    always @(negedge clk) begin
        rsp_t r;
        #1;
        if (rst_n) begin
            if (sbq.size() > 0 && sbq[0].due < cyc) begin
                r = sbq.pop_front();
                vec++; bad++;
                $display("FAIL rsp_missing: port %0d got no rvalid, required at cycle %0d", r.port, r.due);
            end
            if (p0_rvalid || p1_rvalid) begin
                if (sbq.size() == 0) begin
                    vec++; bad++;
                    $display("FAIL rsp_unexpected at cycle %0d: p0_rvalid=%b p1_rvalid=%b required none", cyc, p0_rvalid, p1_rvalid);
                end else begin
                    r = sbq.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(r.due));
                    chk("rsp_port", {30'b0, p1_rvalid, p0_rvalid}, r.port ? 32'd2 : 32'd1);
                    chk("rsp_err", 32'(r.port ? p1_err : p0_err), 32'(r.err));
                    chk("rsp_data", r.port ? p1_rdata : p0_rdata, r.data);
                    chk("rsp_other_quiet", 32'(r.port ? (p0_err || p0_rdata != 0) : (p1_err || p1_rdata != 0)), 32'd0);
                end
            end
        end
    end

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 9) == 0) ? AW'($urandom_range(100, 511)) : AW'($urandom_range(0, 99));
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = f(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_w_en", 32'(mem_w_en), 0);
        chk("rst_mode", 32'(mem_mode), 1);
        chk("rst_addr", 32'(mem_address), 0);
        chk("rst_din", mem_datain, 0);
        chk("rst_outs", {26'b0, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);
        chk("rst_rdata", p0_rdata | p1_rdata, 0);
        load = 0;
        rst_n = 1;
        issue(0, 0, 0, 0);
        repeat (4) tick();
        issue(1, 1, 4, 32'hDEAD_BEEF);
        repeat (4) tick();
        chk("mem4_written", mem[4], 32'hDEAD_BEEF);
        issue(0, 0, 4, 0);
        repeat (4) tick();
        keep = 1;
        issue(0, 0, AW'($urandom_range(0, 99)), 0);
        issue(1, 0, AW'($urandom_range(0, 99)), 0);
        repeat (12) begin
            tick();
            chk("fix_p1_gnt", 32'(f_p1_gnt), 0);
            fcnt += int'(f_p0_gnt);
        end
        chk("fix_p0_grants", 32'(fcnt), 4);
        keep = 0; p0_req = 0; p1_req = 0;
        repeat (4) tick();
        issue(0, 1, 100, 32'h1234_5678);
        repeat (4) tick();
        issue(0, 1, 511, 32'h8765_4321);
        repeat (4) tick();
        chk("mem100_kept", mem[100], f(100));
        chk("mem511_kept", mem[511], f(511));
        issue(0, 1, 7, 32'hCAFE_F00D);
        tick();
        rst_n = 0;
        #1;
        chk("midrst_w_en", 32'(mem_w_en), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_gnt", 32'(p0_gnt), 0);
        chk("midrst_mode", 32'(mem_mode), 1);
        sbq.delete(); pw_valid = 0; cool = 0; last = 1; p0_req = 0; p1_req = 0;
        tick();
        rst_n = 1;
        tick();
        chk("midrst_nowrite", mem[7], f(7));
        issue(0, 0, 7, 0);
        repeat (4) tick();
        repeat (20) tick();
        repeat (300) begin
            tick();
            if (!p0_req && $urandom_range(0, 2) == 0) issue(0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
            if (!p1_req && $urandom_range(0, 2) == 0) issue(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        end
        p0_req = 0; p1_req = 0;
        repeat (6) tick();
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/veda_dmem_arbiter.md
Name: veda_dmem_arbiter

Overview:
Two-port arbiter and access sequencer for the VEDA data memory (32-bit words, 9-bit address, DEPTH valid words). It shares the single memory port between the core load/store unit (port 0) and the loader/debug unit (port 1). It drives the memory's w_en/mode/address/datain controls, one access at a time. Each access is range-checked, and the result returns to the winning requester as a registered response.

Parameters:
ADDR_W, 9, memory address width
DATA_W, 32, data word width
DEPTH, 100, number of valid memory words; addresses >= DEPTH are illegal
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with port 0 highest

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 access request
p0_we  in  1  port 0 write (1) / read (0)
p0_addr  in  ADDR_W  port 0 word address
p0_wdata  in  DATA_W  port 0 write data
p0_gnt  out  1  port 0 grant pulse
p0_rvalid  out  1  port 0 response valid pulse
p0_rdata  out  DATA_W  port 0 read data
p0_err  out  1  port 0 out-of-range flag, qualified by p0_rvalid
p1_*  (same seven signals for port 1)
mem_w_en  out  1  memory write enable
mem_mode  out  1  memory mode: 0 = write/pass-through, 1 = read
mem_address  out  ADDR_W  memory address
mem_datain  out  DATA_W  memory write data
mem_dataout  in  DATA_W  memory read data (combinational from address)
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n); all flops clear immediately on rst_n=0.
- Reset values:
  - state=IDLE
  - all gnt/rvalid/err = 0, all rdata = 0
  - mem_w_en=0, mem_mode=1, mem_address=0, mem_datain=0, busy=0
  - rr_last=1, so port 0 wins the first contention.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle except IDLE.
- IDLE:
  - If any req is high, select the winner. Latch its we/addr/wdata and the winner id, then go to ACCESS.
  - pX_gnt is registered: high for exactly the first cycle of ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - ARB_MODE=0: if only one port requests, it wins. If both request, the port != rr_last wins, and rr_last updates to the winner.
  - ARB_MODE=1: port 0 always wins a tie; rr_last is unused.
- Request rules:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - Inputs are sampled only at the IDLE->ACCESS edge.
  - Keeping req high after gnt is a new request, eligible at the next IDLE.
- ACCESS (one cycle):
  - mem_address = latched addr.
  - Legal write: mem_mode=0, mem_w_en=1, mem_datain=latched wdata.
  - Read: mem_mode=1, mem_w_en=0. mem_dataout is captured at the end of the cycle.
  - Illegal address (addr >= DEPTH): mem_w_en=0, mem_mode=1, nothing captured.
- RESP (one cycle):
  - Winner's pX_rvalid=1.
  - Read: pX_rdata = captured word.
  - Write: pX_rdata = written data, echoing the memory pass-through.
  - Illegal address: pX_err=1 and pX_rdata=0.
  - The other port's rvalid, err and rdata stay at 0.
- Outside ACCESS, memory controls are idle: mem_w_en=0, mem_mode=1, and address/datain hold their last values.
- Latency: req seen in cycle N -> gnt in N+1 -> rvalid in N+2. Next grant no earlier than N+4, so throughput is one access per 3 cycles minimum.
- Simultaneous events: a request arriving while busy waits; it is never dropped, provided the requester holds req. Requests arriving during RESP are evaluated in the following IDLE.
- Reset mid-operation: the pending access is discarded, no rvalid is issued, and mem_w_en drops to 0 asynchronously. This guarantees no partial write after reset deassertion.
- mem_w_en is never high for more than one cycle per grant.

Decomposition:
- Shared package veda_pkg: state encoding (ST_IDLE, ST_ACCESS, ST_RESP), MEM_MODE_WRITE=0 / MEM_MODE_READ=1, default ADDR_W/DATA_W/DEPTH constants.
- One natural sub-module: veda_rr_arb2, a two-requester round-robin/fixed-priority picker with a pointer register. It outputs a one-hot winner and owns rr_last.

Test Plan:
- Reset, then p0 read addr 0 -> p0_gnt in cycle 1, mem_mode=1/addr=0 in cycle 1, p0_rvalid in cycle 2 with p0_rdata=32'h3, p0_err=0.
- p1 write addr 4 data 32'hDEAD_BEEF, then p0 read addr 4 -> exactly one mem_w_en pulse with addr=4; the p0 read returns 32'hDEADBEEF.
- Both ports request continuously with ARB_MODE=0 -> grants alternate p0, p1, p0, p1, spaced 3 cycles apart. With ARB_MODE=1, every grant goes to p0.
- p0 write to addr 100 and addr 511 -> mem_w_en stays 0; p0_rvalid with p0_err=1 and p0_rdata=0; memory contents unchanged.
- rst_n asserted during the ACCESS of a write -> mem_w_en falls immediately, no rvalid, state=IDLE, busy=0; a later read of that address returns its old value.
- Idle bus with no req for 20 cycles -> busy=0, mem_w_en=0, mem_mode=1, no gnt/rvalid pulses.
